// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
// The state encoding and the saturating arithmetic live here so the top level and the counters agree.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WATCH   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // Width of an index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hls_deadlock_stall_counter.sv
// Counts consecutive stalled cycles for one source and flags when the stall is long enough.
// Any gap in the stall restarts the count.
module hls_deadlock_stall_counter
    import hls_deadlock_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int THRESH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic cand,
    output logic confirm
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (!clear && cand) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current cycle counts toward the threshold, hence THRESH-1 prior stalled edges.
    assign confirm = cand && (cnt_q >= THR_M1);

endmodule

// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor beside one HLS dataflow instance: filters AXIS stalls and sub-instance blocks
// through per-source run-length counters and reports the first confirmed source and blocked time.
module hls_deadlock_multi_monitor
    import hls_deadlock_pkg::*;
#(
    parameter  int NUM_AXIS = 2,
    parameter  int NUM_SUB  = 1,
    parameter  int CNT_W    = 8,
    parameter  int THRESH   = 1,
    parameter  int STICKY   = 0,
    localparam int NSRC     = NUM_AXIS + NUM_SUB,
    localparam int SRC_W    = clog2_min1(NSRC)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_SUB-1:0]  inst_idle_sigs,
    input  logic [NUM_SUB-1:0]  inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic [SRC_W-1:0]    block_src,
    output logic [CNT_W-1:0]    block_cnt
);

    generate
        if (NUM_AXIS < 1 || NUM_SUB < 1) begin : g_bad_count
            $error("hls_deadlock_multi_monitor: NUM_AXIS and NUM_SUB must be >= 1");
        end
        if (THRESH == 0 || longint'(THRESH) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_thresh
            $error("hls_deadlock_multi_monitor: THRESH must be in 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] confirm;
    logic            any_cand;
    logic            any_conf;
    logic [SRC_W-1:0] first_src;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] block_src_q, block_src_d;
    logic [CNT_W-1:0] block_cnt_q, block_cnt_d;

    // An idle sub-instance is allowed to look blocked; only busy-and-blocked counts.
    assign cand     = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
    assign any_cand = |cand;
    assign any_conf = |confirm;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            hls_deadlock_stall_counter #(
                .CNT_W  (CNT_W),
                .THRESH (THRESH)
            ) u_cnt (
                .clock   (clock),
                .reset   (reset),
                .clear   (clear),
                .cand    (cand[gi]),
                .confirm (confirm[gi])
            );
        end
    endgenerate

    always_comb begin
        first_src = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (confirm[i]) begin
                first_src = SRC_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        block_src_d = block_src_q;
        block_cnt_d = block_cnt_q;
        if (clear) begin
            state_d     = ST_IDLE;
            block_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WATCH: begin
                    if (any_conf) begin
                        state_d = ST_BLOCKED;
                    end else if (any_cand) begin
                        state_d = ST_WATCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BLOCKED: begin
                    if (STICKY != 0) begin
                        state_d = ST_BLOCKED;
                    end else if (!any_cand) begin
                        state_d = ST_IDLE;
                    end else if (!any_conf) begin
                        state_d = ST_WATCH;
                    end else begin
                        state_d = ST_BLOCKED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // The exit edge still counts the cycle just spent blocked.
            if (state_q != ST_BLOCKED && state_d == ST_BLOCKED) begin
                block_src_d = first_src;
                block_cnt_d = '0;
            end else if (state_q == ST_BLOCKED) begin
                block_cnt_d = CNT_W'(sat_inc(32'(block_cnt_q), 32'(CNT_MAX)));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            block_src_q <= '0;
            block_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            block_src_q <= block_src_d;
            block_cnt_q <= block_cnt_d;
        end
    end

    assign block     = (state_q == ST_BLOCKED);
    assign block_src = block_src_q;
    assign block_cnt = block_cnt_q;

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Bench for hls_deadlock_multi_monitor: three configurations driven in parallel, checked against
// a run-length reference model, a directed vector table, hand sequences and random stimulus.
module tb_hls_deadlock_multi_monitor;

    localparam int NA   = 2;
    localparam int NS   = 1;
    localparam int NSRC = NA + NS;
    localparam int ND   = 3;
    localparam int CMAX = 255;
    localparam int TH[ND] = '{1, 4, 3};
    localparam int ST[ND] = '{0, 0, 1};

    logic          clock;
    logic          reset;
    logic [NA-1:0] axis;
    logic [NS-1:0] idle;
    logic [NS-1:0] iblk;
    logic          clr;

    logic       blk_o [ND];
    logic [1:0] src_o [ND];
    logic [7:0] cnt_o [ND];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-source run lengths and the observable outputs.
    int streak [ND][NSRC];
    bit m_blk  [ND];
    int m_src  [ND];
    int m_cnt  [ND];

    hls_deadlock_multi_monitor #(.NUM_AXIS(NA), .NUM_SUB(NS), .CNT_W(8), .THRESH(1), .STICKY(0)) u_d0 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(iblk), .clear(clr), .block(blk_o[0]), .block_src(src_o[0]), .block_cnt(cnt_o[0]));
    hls_deadlock_multi_monitor #(.NUM_AXIS(NA), .NUM_SUB(NS), .CNT_W(8), .THRESH(4), .STICKY(0)) u_d1 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(iblk), .clear(clr), .block(blk_o[1]), .block_src(src_o[1]), .block_cnt(cnt_o[1]));
    hls_deadlock_multi_monitor #(.NUM_AXIS(NA), .NUM_SUB(NS), .CNT_W(8), .THRESH(3), .STICKY(1)) u_d2 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(iblk), .clear(clr), .block(blk_o[2]), .block_src(src_o[2]), .block_cnt(cnt_o[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < NSRC; i++) streak[d][i] = 0;
            m_blk[d] = 1'b0;
            m_src[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    // One clock edge of the specification's rules, using the inputs present before the edge.
    task automatic model_edge();
        bit c [NSRC];
        for (int i = 0; i < NA; i++) c[i] = axis[i];
        for (int j = 0; j < NS; j++) c[NA + j] = iblk[j] & ~idle[j];
        for (int d = 0; d < ND; d++) begin
            int  first = -1;
            bit  nb;
            for (int i = 0; i < NSRC; i++) begin
                if (c[i] && (streak[d][i] + 1 >= TH[d]) && first < 0) first = i;
                streak[d][i] = (clr || !c[i]) ? 0 : streak[d][i] + 1;
            end
            if (clr)                        nb = 1'b0;
            else if (m_blk[d] && ST[d] != 0) nb = 1'b1;
            else                            nb = (first >= 0);
            if (clr) begin
                m_cnt[d] = 0;
            end else if (!m_blk[d] && nb) begin
                m_cnt[d] = 0;
                m_src[d] = first;
            end else if (m_blk[d]) begin
                m_cnt[d] = (m_cnt[d] >= CMAX) ? CMAX : m_cnt[d] + 1;
            end
            m_blk[d] = nb;
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("model d%0d block", d), int'(blk_o[d]), int'(m_blk[d]));
            chk($sformatf("model d%0d block_src", d), int'(src_o[d]), m_src[d]);
            chk($sformatf("model d%0d block_cnt", d), int'(cnt_o[d]), m_cnt[d]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_model();
    endtask

    task automatic set_in(input logic [NA-1:0] a, input logic i_idle, input logic i_blk, input logic c);
        axis = a;
        idle = i_idle;
        iblk = i_blk;
        clr  = c;
    endtask

    task automatic hard_reset();
        @(negedge clock);
        set_in(2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NA-1:0] axis;
        logic          idle;
        logic          iblk;
        logic          clr;
        logic          exp_blk;
        int            exp_src;
        int            exp_cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Expected outputs of the THRESH=1 non-sticky instance after each vector's edge.
        vecs[0]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[2]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[3]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[4]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0};
        vecs[5]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1};
        vecs[6]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2};
        vecs[7]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3};
        vecs[8]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0};
        vecs[9]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[10] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
        vecs[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2};

        reset = 1'b1;
        set_in(2'b00, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset d%0d block", d), int'(blk_o[d]), 0);
            chk($sformatf("reset d%0d block_src", d), int'(src_o[d]), 0);
            chk($sformatf("reset d%0d block_cnt", d), int'(cnt_o[d]), 0);
        end

        for (int v = 0; v < 12; v++) begin
            set_in(vecs[v].axis, vecs[v].idle, vecs[v].iblk, vecs[v].clr);
            step();
            $display("vec %0d: axis=%b idle=%b iblk=%b clr=%b -> block=%0d src=%0d cnt=%0d",
                     v, vecs[v].axis, vecs[v].idle, vecs[v].iblk, vecs[v].clr,
                     blk_o[0], src_o[0], cnt_o[0]);
            chk($sformatf("vec%0d block", v), int'(blk_o[0]), int'(vecs[v].exp_blk));
            chk($sformatf("vec%0d block_src", v), int'(src_o[0]), vecs[v].exp_src);
            chk($sformatf("vec%0d block_cnt", v), int'(cnt_o[0]), vecs[v].exp_cnt);
        end

        // THRESH=4: three-cycle stall is ignored, four-cycle stall confirms.
        hard_reset();
        set_in(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            chk("thr4 short block", int'(blk_o[1]), 0);
        end
        set_in(2'b00, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("thr4 edge%0d block", k), int'(blk_o[1]), (k == 4) ? 1 : 0);
        end
        chk("thr4 block_src", int'(src_o[1]), 0);
        $display("seq thr4: block=%0d src=%0d", blk_o[1], src_o[1]);

        // Idle masking, then release.
        hard_reset();
        set_in(2'b00, 1'b1, 1'b1, 1'b0);
        repeat (100) step();
        chk("idle mask block", int'(blk_o[1]), 0);
        set_in(2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("unmask edge%0d block", k), int'(blk_o[1]), (k == 4) ? 1 : 0);
        end
        chk("unmask block_src", int'(src_o[1]), NA);
        $display("seq idle: block=%0d src=%0d", blk_o[1], src_o[1]);

        // Simultaneous confirm picks lowest index; long hold saturates.
        hard_reset();
        set_in(2'b01, 1'b0, 1'b1, 1'b0);
        repeat (4) step();
        chk("tie block", int'(blk_o[1]), 1);
        chk("tie block_src", int'(src_o[1]), 0);
        repeat (300) step();
        chk("sat block_cnt d1", int'(cnt_o[1]), CMAX);
        chk("sat block_cnt d2", int'(cnt_o[2]), CMAX);
        $display("seq sat: cnt d1=%0d d2=%0d", cnt_o[1], cnt_o[2]);

        // Sticky hold and clear.
        set_in(2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        chk("sticky hold block", int'(blk_o[2]), 1);
        chk("nonsticky drop block", int'(blk_o[1]), 0);
        set_in(2'b00, 1'b0, 1'b0, 1'b1);
        step();
        chk("clear block", int'(blk_o[2]), 0);
        chk("clear block_cnt", int'(cnt_o[2]), 0);
        set_in(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        set_in(2'b01, 1'b0, 1'b0, 1'b1);
        step();
        chk("clear beats confirm", int'(blk_o[2]), 0);
        set_in(2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("restart edge%0d block", k), int'(blk_o[2]), (k == 3) ? 1 : 0);
        end
        $display("seq sticky: block=%0d cnt=%0d", blk_o[2], cnt_o[2]);

        // Asynchronous reset while blocked, between clock edges.
        repeat (5) step();
        chk("pre-reset block_cnt", int'(cnt_o[2]), 5);
        reset = 1'b1;
        #1;
        chk("async reset block", int'(blk_o[2]), 0);
        chk("async reset block_cnt", int'(cnt_o[2]), 0);
        model_reset();
        #1;
        reset = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 1'b0);
        $display("seq async reset: block=%0d cnt=%0d", blk_o[2], cnt_o[2]);

        // Random traffic against the model.
        hard_reset();
        for (int n = 0; n < 600; n++) begin
            set_in({($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0)},
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 40) == 0));
            step();
        end
        $display("random phase done: block=%0d/%0d/%0d", blk_o[0], blk_o[1], blk_o[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
